// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Read-side scheduler for the asynchronous FIFO. Shares the single FIFO read port
//   between NumReq consumers in the read clock domain using round-robin grants with
//   bounded bursts and a release after too many consecutive stalled grant cycles.
//
// Ports
//   read_clk    read-domain clock, all logic on posedge
//   read_rst_n  asynchronous active-low reset
//   req         per-consumer request (level)
//   ready       per-consumer "can take a word next cycle"
//   fifo_empty  FIFO empty flag from read_ctrl
//   fifo_rdata  FIFO read data, captured when read_en is accepted
//   read_en     read strobe to read_ctrl, never asserted while fifo_empty
//   grant       one-hot current owner (registered), zero while idle
//   out_data    registered copy of the word read
//   out_valid   out_data valid this cycle
//   out_dest    one-hot consumer that owns out_data

module fifo_read_arbiter #(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned NumReq       = 4,
    parameter int unsigned BurstLen     = 4,
    parameter int unsigned EmptyTimeout = 8
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic [NumReq-1:0]    req,
    input  logic [NumReq-1:0]    ready,
    input  logic                 fifo_empty,
    input  logic [DataWidth-1:0] fifo_rdata,
    output logic                 read_en,
    output logic [NumReq-1:0]    grant,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_valid,
    output logic [NumReq-1:0]    out_dest
);

    localparam int unsigned IdxW   = $clog2(NumReq);
    localparam int unsigned BeatW  = $clog2(BurstLen) + 1;
    localparam int unsigned StallW = $clog2(EmptyTimeout) + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [NumReq-1:0]     grant_q, grant_d;
    logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [StallW-1:0]     stall_cnt_q, stall_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic [NumReq-1:0]     out_dest_q, out_dest_d;

    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;
    logic                  owner_req;
    logic                  owner_ready;
    logic                  stall;
    logic                  last_beat;
    logic                  timeout;
    logic                  release_grant;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int unsigned cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = (32'(last_q) + k) % NumReq;
            if (!pick_valid && req[cand[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign owner_req   = req[owner_q];
    assign owner_ready = ready[owner_q];

    assign read_en   = (state_q == StBurst) & owner_req & owner_ready & ~fifo_empty;
    assign stall     = (state_q == StBurst) & owner_req & ~read_en;
    assign last_beat = read_en & (beat_cnt_q == BeatW'(BurstLen - 1));
    assign timeout   = stall & (stall_cnt_q == StallW'(EmptyTimeout - 1));
    // A dropped request can never coincide with a read, so no extra qualifier is needed.
    assign release_grant = last_beat | ~owner_req | timeout;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        out_valid_d = read_en;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;

        // The word of an accepted read is presented on the following cycle,
        // tagged with the owner at issue time (also for the final beat).
        if (read_en) begin
            out_data_d = fifo_rdata;
            out_dest_d = grant_q;
        end

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d     = StBurst;
                    owner_d     = pick_idx;
                    grant_d     = NumReq'(1) << pick_idx;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            StBurst: begin
                if (read_en) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    stall_cnt_d = '0;
                end else if (stall) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if (release_grant) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_q      <= IdxW'(NumReq - 1);
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: table vectors for the first grant after reset,
// directed multi-cycle sequences, and a long random run against a behavioural model.

module tb_fifo_read_arbiter;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int ET = 8;
    localparam int DW = 8;
    // Worst burst: every beat preceded by ET-1 stalls, plus one idle cycle per grant.
    localparam int StarveBound = (N - 1) * (BL * ET + 1) + 1;

    logic          read_clk = 1'b0;
    logic          read_rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  ready = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          read_en;
    logic [N-1:0]  grant;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [N-1:0]  out_dest;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];

    // Behavioural model state
    bit            m_busy;
    int            m_owner;
    int            m_last;
    int            m_beats;
    int            m_stalls;
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [N-1:0]  m_dest;

    // Values sampled by the most recent tick
    logic [N-1:0]  s_grant;
    logic [N-1:0]  s_dest;
    logic          s_rd;
    logic          s_ov;

    bit track_starve = 1'b0;
    int wait_cnt[N];
    int max_wait[N];

    always #5 read_clk = ~read_clk;

    fifo_read_arbiter #(
        .DataWidth   (DW),
        .NumReq      (N),
        .BurstLen    (BL),
        .EmptyTimeout(ET)
    ) dut (
        .read_clk  (read_clk),
        .read_rst_n(read_rst_n),
        .req       (req),
        .ready     (ready),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .read_en   (read_en),
        .grant     (grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_dest  (out_dest)
    );

    typedef struct {
        logic [N-1:0] req;
        int           words;
        logic [N-1:0] ready;
        logic [N-1:0] exp_grant;
        logic         exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fifo_pins();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_beats  = 0;
        m_stalls = 0;
        m_ov     = 1'b0;
        m_od     = '0;
        m_dest   = '0;
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] one = 1;
        return m_busy ? (one << m_owner) : '0;
    endfunction

    function automatic bit m_rd();
        return m_busy && req[m_owner] && ready[m_owner] && (fq.size() > 0);
    endfunction

    // One clock: compare at the falling edge, advance the model, cross the rising edge.
    task automatic tick();
        bit           rd;
        bit           rel;
        bit           found;
        int           idx;
        logic [N-1:0] g;
        @(negedge read_clk);
        rd = m_rd();
        g  = m_grant();
        s_grant = grant;
        s_rd    = read_en;
        s_ov    = out_valid;
        s_dest  = out_dest;
        checks++;
        if ({grant, read_en, out_valid, out_dest, out_data} !== {g, rd, m_ov, m_dest, m_od}) begin
            errors++;
            $display("FAIL model t=%0t (actual/required) grant=%b/%b rd=%b/%b ov=%b/%b dest=%b/%b data=%h/%h",
                     $time, grant, g, read_en, rd, out_valid, m_ov, out_dest, m_dest, out_data, m_od);
        end
        checks++;
        if (!$onehot0(grant) || (read_en && (fifo_empty || grant == '0))) begin
            errors++;
            $display("FAIL invariant t=%0t grant=%b read_en=%b fifo_empty=%b required onehot0, rd->!empty&grant",
                     $time, grant, read_en, fifo_empty);
        end
        if (track_starve) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
            end
        end

        m_ov = rd;
        if (rd) begin
            m_od   = fq[0];
            m_dest = g;
        end
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    m_busy   = 1'b1;
                    m_owner  = idx;
                    m_beats  = 0;
                    m_stalls = 0;
                end
            end
        end else begin
            rel = 1'b0;
            if (rd) begin
                m_beats++;
                m_stalls = 0;
                rel = (m_beats == BL);
            end else if (req[m_owner]) begin
                m_stalls++;
                rel = (m_stalls == ET);
            end else begin
                rel = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end

        @(posedge read_clk);
        #1;
        if (rd) void'(fq.pop_front());
        fifo_pins();
    endtask

    task automatic do_reset();
        req   = '0;
        ready = '0;
        read_rst_n = 1'b0;
        model_reset();
        fq.delete();
        fifo_pins();
        #7;
        @(posedge read_clk);
        #1;
        read_rst_n = 1'b1;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
        fifo_pins();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [N-1:0] gseq[4];
        logic [N-1:0] prev_g;
        int ng, cnt0, cnt1, cnt2, cnt3;
        int reads, run_len, k;
        bit started, done;

        // Reset state
        do_reset();
        check("reset_grant", grant, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_dest", out_dest, 0);
        check("reset_read_en", read_en, 0);

        // First grant after reset searches from req[0]
        vecs[0] = '{4'b1111, 1, 4'b1111, 4'b0001, 1'b1};
        vecs[1] = '{4'b0110, 1, 4'b0110, 4'b0010, 1'b1};
        vecs[2] = '{4'b1000, 0, 4'b1111, 4'b1000, 1'b0};
        vecs[3] = '{4'b0100, 3, 4'b1011, 4'b0100, 1'b0};
        vecs[4] = '{4'b1010, 2, 4'b1111, 4'b0010, 1'b1};
        vecs[5] = '{4'b0000, 2, 4'b1111, 4'b0000, 1'b0};
        vecs[6] = '{4'b1100, 1, 4'b1100, 4'b0100, 1'b1};
        foreach (vecs[i]) begin
            do_reset();
            push_words(vecs[i].words, 8'h40);
            req   = vecs[i].req;
            ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d_read_en", i), read_en, vecs[i].exp_rd);
        end

        // All request, 12 words: rotating 4-beat bursts
        do_reset();
        push_words(12, 8'h10);
        req = 4'b1111;
        ready = 4'b1111;
        ng = 0; prev_g = '0; cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (s_grant != 0 && prev_g == 0 && ng < 4) begin
                gseq[ng] = s_grant;
                ng++;
            end
            prev_g = s_grant;
            if (s_ov) begin
                if (s_dest == 4'b0001) cnt0++;
                if (s_dest == 4'b0010) cnt1++;
                if (s_dest == 4'b0100) cnt2++;
                if (s_dest == 4'b1000) cnt3++;
            end
        end
        check("t1_grants_seen", ng, 4);
        check("t1_grant0", gseq[0], 4'b0001);
        check("t1_grant1", gseq[1], 4'b0010);
        check("t1_grant2", gseq[2], 4'b0100);
        check("t1_grant3", gseq[3], 4'b1000);
        check("t1_words_dest0", cnt0, 4);
        check("t1_words_dest1", cnt1, 4);
        check("t1_words_dest2", cnt2, 4);
        check("t1_words_dest3", cnt3, 0);

        // Sole requester, 2 words, then empty-timeout release
        do_reset();
        push_words(2, 8'h80);
        req = 4'b0100;
        ready = 4'b1111;
        reads = 0; run_len = 0; started = 1'b0; done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            reads += int'(s_rd);
            if (!done) begin
                if (s_grant == 4'b0100) begin
                    started = 1'b1;
                    run_len++;
                end else if (started) begin
                    done = 1'b1;
                end
            end
        end
        check("t2_reads", reads, 2);
        check("t2_released", done, 1);
        check("t2_grant_cycles", run_len, 2 + ET);

        // Owner drops request after 2 beats with req[3] pending
        do_reset();
        push_words(10, 8'hA0);
        req = 4'b1001;
        ready = 4'b1111;
        reads = 0; cnt0 = 0; k = 0;
        while (reads < 2 && k < 20) begin
            tick();
            if (s_rd && s_grant == 4'b0001) reads++;
            if (s_ov && s_dest == 4'b0001) cnt0++;
            k++;
        end
        check("t3_two_beats_reached", reads, 2);
        req = 4'b1000;
        prev_g = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (s_ov && s_dest == 4'b0001) cnt0++;
            if (prev_g == 0 && s_grant != 0 && s_grant != 4'b0001) prev_g = s_grant;
        end
        check("t3_next_grant", prev_g, 4'b1000);
        check("t3_dest0_pulses", cnt0, 2);

        // ready toggling mid-burst only gates read_en
        do_reset();
        push_words(10, 8'hC0);
        req = 4'b0001;
        ready = 4'b0001;
        tick();
        reads = 0; run_len = 0; k = 0; done = 1'b0;
        while (!done && k < 20) begin
            ready[0] = (k % 2 == 0);
            tick();
            if (s_grant == 4'b0001) begin
                run_len++;
                reads += int'(s_rd);
                check("t4_rd_gating", s_rd, ready[0]);
            end else begin
                done = 1'b1;
            end
            k++;
        end
        check("t4_released", done, 1);
        check("t4_reads", reads, BL);
        check("t4_grant_cycles", run_len, 2 * BL - 1);

        // Asynchronous reset one cycle after a read
        do_reset();
        push_words(10, 8'hE0);
        req = 4'b0010;
        ready = 4'b1111;
        tick();
        tick();
        check("t5_read_issued", s_rd, 1);
        check("t5_valid_pending", out_valid, 1);
        read_rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_read_en", read_en, 0);
        #2;
        read_rst_n = 1'b1;
        req = 4'b1111;
        tick();
        check("t5_first_after_reset", grant, 4'b0001);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            max_wait[i] = 0;
        end
        track_starve = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(2) == 0 && fq.size() < 16) fq.push_back(DW'($urandom));
            fifo_pins();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                ready[i] = ($urandom_range(3) != 0);
            end
            tick();
        end
        track_starve = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("starve_bound_req%0d", i), max_wait[i] <= StarveBound, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
